// File: rtl/palette_ram.sv
// Dual-address RGB palette memory with per-channel write masks, read-after-write
// bypass, and a hardware sweep that wipes every entry to CLEAR_VALUE.
module palette_ram #(
    parameter int                          CH_W        = 8,
    parameter int                          CHANNELS    = 3,
    parameter int                          ADDR_W      = 8,
    parameter int                          EDGE_MODE   = 1,
    parameter string                       INIT_FILE   = "",
    parameter logic [CH_W*CHANNELS-1:0]    CLEAR_VALUE = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_read,
    input  logic [ADDR_W-1:0]          i_read_addr,
    input  logic                       i_write,
    input  logic [ADDR_W-1:0]          i_write_addr,
    input  logic [CH_W*CHANNELS-1:0]   i_data,
    input  logic [CHANNELS-1:0]        i_wr_mask,
    input  logic                       i_clear,
    output logic [CH_W*CHANNELS-1:0]   o_rgb_data,
    output logic                       o_valid,
    output logic                       o_busy
);

    localparam int DATA_W = CH_W * CHANNELS;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic [1:0]          rd_hist_q, rd_hist_d;
    logic [1:0]          wr_hist_q, wr_hist_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [CHANNELS-1:0] wr_mask_q, wr_mask_d;
    logic [DATA_W-1:0]   rgb_q, rgb_d;
    logic                valid_q, valid_d;

    logic                rd_req, wr_req, rd_fire, wr_fire;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [CHANNELS-1:0] mem_wmask;
    logic [DATA_W-1:0]   rd_word;

    // Bit 0 of each history is the strobe as registered at the request edge.
    always_comb begin
        rd_req  = (EDGE_MODE != 0) ? (rd_hist_q[0] & ~rd_hist_q[1]) : rd_hist_q[0];
        wr_req  = (EDGE_MODE != 0) ? (wr_hist_q[0] & ~wr_hist_q[1]) : wr_hist_q[0];
        rd_fire = rd_req && (state_q == IDLE);
        wr_fire = wr_req && (state_q == IDLE);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr_q;
        mem_wdata = wr_data_q;
        mem_wmask = wr_mask_q;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = CLEAR_VALUE;
            mem_wmask = '1;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    // A read colliding with a write returns the post-write word.
    always_comb begin
        rd_word = mem[rd_addr_q];
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_fire && (wr_addr_q == rd_addr_q) && wr_mask_q[c]) begin
                rd_word[c*CH_W +: CH_W] = wr_data_q[c*CH_W +: CH_W];
            end
        end
    end

    always_comb begin
        rd_hist_d = {rd_hist_q[0], i_read};
        wr_hist_d = {wr_hist_q[0], i_write};
        rd_addr_d = i_read_addr;
        wr_addr_d = i_write_addr;
        wr_data_d = i_data;
        wr_mask_d = i_wr_mask;
        valid_d   = rd_fire;
        rgb_d     = rd_fire ? rd_word : rgb_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (i_clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            rd_hist_q <= '0;
            wr_hist_q <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
            rgb_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            rd_hist_q <= rd_hist_d;
            wr_hist_q <= wr_hist_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            rgb_q     <= rgb_d;
            valid_q   <= valid_d;
        end
    end

    // Storage is never reset; a reset edge only suppresses the write.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && mem_we) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (mem_wmask[c]) begin
                    mem[mem_waddr][c*CH_W +: CH_W] <= mem_wdata[c*CH_W +: CH_W];
                end
            end
        end
    end

    assign o_rgb_data = rgb_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;

endmodule
